// File: rtl/program_memory_pkg.sv
// Shared types and constants for the instruction memory and boot loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package program_memory_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

  // Default terminator and filler words, also used by the decoder and debug unit
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0000;

  // Number of stream bytes that make up one instruction word
  function automatic int bytes_per_word(input int nb_data);
    return nb_data / 8;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into NB_DATA-bit words.
// Latency: word is presented combinationally with its final byte (o_word_done same cycle).
// Backpressure: none internally; caller gates i_accept with its own valid/ready handshake.
module byte_word_assembler
  import program_memory_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [7:0]         i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_done
);

  localparam int NB_BYTES = bytes_per_word(NB_DATA);
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_BYTES - 1);

  logic [NB_IDX-1:0]  byte_idx;
  logic [NB_DATA-1:0] asm_reg;

  // The final byte completes the word without first landing in the register
  assign o_word_done = i_accept && (byte_idx == LAST_IDX);

  // Present the completed word: top byte comes straight from the stream
  always_comb begin
    o_word = asm_reg;
    o_word[NB_DATA-1 -: 8] = i_byte;
  end

  // Byte index and assembly register; a restart drops any partial word
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      byte_idx <= '0;
      asm_reg  <= '0;
    end else if (i_clear || o_word_done) begin
      byte_idx <= '0;
      asm_reg  <= '0;
    end else if (i_accept) begin
      byte_idx <= byte_idx + 1'b1;
      for (int k = 0; k < NB_BYTES; k++) begin
        if (byte_idx == NB_IDX'(k)) begin
          asm_reg[8*k +: 8] <= i_byte;
        end
      end
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Instruction memory with a byte-stream boot loader and guarded combinational fetch port.
// Latency: written word readable the cycle after its final byte; fetch read is combinational.
// Backpressure: o_byte_ready high only while loading and no start pulse is present.
module program_memory_loader
  import program_memory_pkg::*;
#(
  parameter int                 NB_ADDR      = 32,
  parameter int                 NB_DATA      = 32,
  parameter int                 ROM_DEPTH    = 32,
  parameter int                 NB_WORD_ADDR = $clog2(ROM_DEPTH),
  parameter logic [NB_DATA-1:0] HALT_WORD    = NB_DATA'(DEFAULT_HALT_WORD),
  parameter logic [NB_DATA-1:0] NOP_WORD     = NB_DATA'(DEFAULT_NOP_WORD)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load_start,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_byte_ready,
  input  logic [NB_ADDR-1:0]      i_read_addr,
  output logic [NB_DATA-1:0]      o_data,
  output logic                    o_busy,
  output logic                    o_load_done,
  output logic                    o_overflow,
  output logic [NB_WORD_ADDR:0]   o_word_count
);

  localparam logic [NB_WORD_ADDR:0] DEPTH_CNT = (NB_WORD_ADDR+1)'(ROM_DEPTH);

  loader_state_t         state;
  logic [NB_WORD_ADDR:0] word_count;
  logic [NB_WORD_ADDR:0] next_count;
  logic [NB_DATA-1:0]    mem [ROM_DEPTH];
  logic                  byte_accept;
  logic                  word_done;
  logic [NB_DATA-1:0]    word;

  // A start pulse wins over a coincident byte
  assign o_byte_ready = (state == ST_LOAD) && !i_load_start;
  assign byte_accept  = i_byte_valid && o_byte_ready;
  assign next_count   = word_count + 1'b1;

  byte_word_assembler #(
    .NB_DATA (NB_DATA)
  ) u_assembler (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (i_load_start),
    .i_accept    (byte_accept),
    .i_byte      (i_byte),
    .o_word      (word),
    .o_word_done (word_done)
  );

  // Loader FSM and write pointer; halt takes precedence over a full memory
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      word_count <= '0;
    end else if (i_load_start) begin
      state      <= ST_LOAD;
      word_count <= '0;
    end else if (word_done) begin
      word_count <= next_count;
      if (word == HALT_WORD) begin
        state <= ST_DONE;
      end else if (next_count == DEPTH_CNT) begin
        state <= ST_ERROR;
      end
    end
  end

  // Memory array is deliberately left unreset; word_count guards visibility
  always_ff @(posedge i_clock) begin
    if (word_done) begin
      mem[word_count[NB_WORD_ADDR-1:0]] <= word;
    end
  end

  // Fetch port: only words written by the current/last load are visible
  always_comb begin
    o_data = NOP_WORD;
    if ((i_read_addr < NB_ADDR'(word_count)) && (i_read_addr < NB_ADDR'(ROM_DEPTH))) begin
      o_data = mem[i_read_addr[NB_WORD_ADDR-1:0]];
    end
  end

  assign o_busy       = (state == ST_LOAD);
  assign o_load_done  = (state == ST_DONE);
  assign o_overflow   = (state == ST_ERROR);
  assign o_word_count = word_count;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader (NB_DATA=32, ROM_DEPTH=4).
// Latency: expects each completed word readable right after its final byte edge.
// Backpressure: models ready as LOAD && !start and checks it on every driven cycle.
module tb_program_memory_loader;

  localparam int NB_ADDR   = 32;
  localparam int NB_DATA   = 32;
  localparam int ROM_DEPTH = 4;

  logic        i_clock;
  logic        i_reset;
  logic        i_load_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic [31:0] i_read_addr;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_load_done;
  logic        o_overflow;
  logic [2:0]  o_word_count;

  program_memory_loader #(
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .ROM_DEPTH (ROM_DEPTH)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load_start (i_load_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .i_read_addr  (i_read_addr),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_load_done  (o_load_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 idle, 1 load, 2 done, 3 error
  int          m_state = 0;
  int          m_cnt   = 0;
  int          m_idx   = 0;
  logic [31:0] m_asm   = '0;
  logic [31:0] m_mem [ROM_DEPTH];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic model_restart();
    m_state = 1;
    m_cnt   = 0;
    m_idx   = 0;
    m_asm   = '0;
    exp_q.delete();
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_idx   = 0;
    m_asm   = '0;
    exp_q.delete();
  endtask

  // Returns 1 when the byte completes a word
  task automatic model_accept(input logic [7:0] b, output bit done);
    done = 0;
    m_asm[8*m_idx +: 8] = b;
    if (m_idx == 3) begin
      m_mem[m_cnt] = m_asm;
      exp_q.push_back(m_asm);
      m_cnt++;
      if (m_asm == 32'hFFFF_FFFF) m_state = 2;
      else if (m_cnt == ROM_DEPTH) m_state = 3;
      m_idx = 0;
      m_asm = '0;
      done  = 1;
    end else begin
      m_idx++;
    end
  endtask

  // One cycle of stimulus; checks ready, and on word completion pops the scoreboard
  task automatic drive(input logic [7:0] b, input bit vld, input bit start);
    bit   exp_rdy;
    bit   done;
    logic [31:0] exp_w;
    @(negedge i_clock);
    i_load_start = start;
    i_byte_valid = vld;
    i_byte       = b;
    #1;
    exp_rdy = (m_state == 1) && !start;
    check("byte_ready", {31'b0, o_byte_ready}, {31'b0, exp_rdy});
    @(posedge i_clock);
    #1;
    i_load_start = 1'b0;
    i_byte_valid = 1'b0;
    done = 0;
    if (start) model_restart();
    else if (vld && exp_rdy) model_accept(b, done);
    if (done) begin
      check("word_count", {29'b0, o_word_count}, 32'(m_cnt));
      i_read_addr = 32'(m_cnt - 1);
      #1;
      exp_w = exp_q.pop_front();
      check("word_write", o_data, exp_w);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, maxgap)) drive(8'h00, 1'b0, 1'b0);
      drive(w[8*k +: 8], 1'b1, 1'b0);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_d;
    check({tag, "_busy"},  {31'b0, o_busy},       {31'b0, m_state == 1});
    check({tag, "_done"},  {31'b0, o_load_done},  {31'b0, m_state == 2});
    check({tag, "_ovf"},   {31'b0, o_overflow},   {31'b0, m_state == 3});
    check({tag, "_cnt"},   {29'b0, o_word_count}, 32'(m_cnt));
    check({tag, "_rdy"},   {31'b0, o_byte_ready}, {31'b0, m_state == 1});
    for (int a = 0; a < 6; a++) begin
      i_read_addr = 32'(a);
      #1;
      exp_d = (a < m_cnt) ? m_mem[a] : 32'h0;
      check($sformatf("%s_rd%0d", tag, a), o_data, exp_d);
    end
  endtask

  initial begin
    logic [31:0] w;
    i_reset      = 1'b1;
    i_load_start = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    i_read_addr  = '0;
    model_reset();

    // Reset state, both during and after reset
    #12;
    check_all("in_rst");
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check_all("post_rst");

    // Basic load terminated by halt
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h78, 1'b1, 1'b0);
    drive(8'h56, 1'b1, 1'b0);
    drive(8'h34, 1'b1, 1'b0);
    drive(8'h12, 1'b1, 1'b0);
    send_word(32'hFFFF_FFFF, 0);
    check_all("halt");
    check("halt_mem0", m_mem[0], 32'h1234_5678);
    drive(8'h5A, 1'b1, 1'b0);
    check_all("halt_ignore");

    // Overflow: 16 bytes without halt, then extra bytes ignored
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(8'(i + 1), 1'b1, 1'b0);
    check_all("ovf");
    for (int i = 0; i < 4; i++) drive(8'hEE, 1'b1, 1'b0);
    check_all("ovf_ignore");

    // Restart mid-word discards the partial bytes
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
    send_word(32'hAABB_CCDD, 0);
    send_word(32'hFFFF_FFFF, 0);
    check_all("restart");

    // Gapped valid, and a start coinciding with a valid byte
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h33, 1'b1, 1'b0);
    drive(8'h44, 1'b1, 1'b0);
    drive(8'h99, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      w = {$urandom_range(0, 32'h7FFF_FFFF)};
      send_word(w, 3);
    end
    send_word(32'hFFFF_FFFF, 3);
    check_all("gapped");

    // Reset during a load, then a normal load
    drive(8'h00, 1'b0, 1'b1);
    send_word(32'hCAFE_F00D, 0);
    drive(8'hA1, 1'b1, 1'b0);
    drive(8'hA2, 1'b1, 1'b0);
    @(negedge i_clock);
    i_reset = 1'b1;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check_all("mid_rst_rel");
    drive(8'h00, 1'b0, 1'b1);
    send_word(32'h0BAD_BEEF, 1);
    send_word(32'hFFFF_FFFF, 1);
    check_all("reload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Instruction memory for the pipelined processor, with a built-in byte-stream boot loader. The host link (UART/debug unit) streams program bytes through a valid/ready port. The block assembles them little-endian into NB_DATA-bit words and writes them at auto-incrementing addresses. Loading stops on a halt word or flags an overflow. The fetch stage reads combinationally, and unloaded addresses return a NOP word.

## Interface
- NB_ADDR, 32, width of fetch read address (word index)
- NB_DATA, 32, instruction width; must be a multiple of 8
- ROM_DEPTH, 32, number of words
- NB_WORD_ADDR, $clog2(ROM_DEPTH), internal write-pointer width
- HALT_WORD, 32'hFFFF_FFFF, word that terminates a load; it is stored
- NOP_WORD, 32'h0000_0000, value returned for unloaded/out-of-range addresses

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_load_start  in  1  pulse: begin (or restart) a load
- i_byte_valid  in  1  byte-stream valid
- i_byte  in  8  byte-stream data
- o_byte_ready  out  1  byte accepted when valid && ready
- i_read_addr  in  NB_ADDR  fetch word address
- o_data  out  NB_DATA  fetched instruction, combinational
- o_busy  out  1  high in LOAD
- o_load_done  out  1  high in DONE
- o_overflow  out  1  high in ERROR
- o_word_count  out  NB_WORD_ADDR+1  words written by the current/last load

## Operation
- FSM states: IDLE, LOAD, DONE, ERROR. Reset enters IDLE.
- i_load_start from any state: go to LOAD; clear word_count, byte index and assembly register.
- o_byte_ready = (state==LOAD) && !i_load_start. A start therefore has priority, and a coincident byte is not accepted.
- Byte index b counts 0..NB_DATA/8-1. Byte b lands in bits [8b+7:8b], little-endian.
- The edge accepting the final byte does three things:
  - writes {byte, assembled lower bytes} at address word_count;
  - increments word_count;
  - clears b to 0.
- On that same edge:
  - if the written word == HALT_WORD, go to DONE;
  - else if the new word_count == ROM_DEPTH, go to ERROR.
  - HALT_WORD written into the last location goes to DONE, not ERROR.
- DONE/ERROR ignore bytes (ready low) until the next i_load_start.
- A partial word left when a restart occurs is discarded.
- Read: o_data = mem[i_read_addr] if i_read_addr < word_count and i_read_addr < ROM_DEPTH, else NOP_WORD. Reads are legal in every state. During LOAD, already-written words are visible.
- Memory contents are not reset. Reset only clears word_count, so all reads return NOP_WORD after reset.

## Timing
- Reset values: o_byte_ready=0, o_busy=0, o_load_done=0, o_overflow=0, o_word_count=0.
- o_data derives from reset state, so it reads NOP_WORD during reset.
- Status outputs decode the registered state and change the cycle after the causing edge.
- o_byte_ready rises the cycle after the start pulse.
- Throughput: one byte per cycle, i.e. one word every NB_DATA/8 accepted bytes.
- Write-to-read latency: 0 cycles after the write edge. The word is readable combinationally in the following cycle, because o_data and word_count update on the same edge.
- Reset asserted mid-load: immediate return to IDLE. The partial word is lost, and words already written stay in the array but are unreadable.

## Structure
- Shared package `program_memory_pkg`:
  - FSM state enum;
  - default HALT_WORD/NOP_WORD constants, shared with the decoder and debug unit.
- One sub-module, `byte_word_assembler`, holds the byte index, shift/assembly register and word-complete strobe.
- The top level holds the FSM, write pointer, memory array and read guard.

## Test plan
All scenarios use NB_DATA=32, ROM_DEPTH=4.
- Reset, then read addr 0..5 -> every read returns 32'h0; all status outputs are 0.
- Start, then bytes 78 56 34 12, FF FF FF FF -> mem[0]=32'h12345678, mem[1]=HALT_WORD, o_word_count=2, o_load_done=1; read addr 2 returns 32'h0.
- Start, then 16 bytes with no halt -> o_overflow=1 after the 4th word, o_byte_ready=0; further bytes are ignored and word_count stays 4.
- Start, 2 bytes, start again, then 8 bytes (word 32'hAABBCCDD, then halt) -> mem[0]=32'hAABBCCDD; the partial bytes are discarded.
- i_byte_valid gapped randomly, and i_load_start coincident with a valid byte -> the coincident byte is not accepted; assembled values are unaffected by gaps.
- Assert reset after 1.5 words during LOAD -> state IDLE next cycle, o_word_count=0, reads return NOP; a following load works normally.
